// File: rtl/game_ctrl_if.sv
// Bundles the game sequencer's frame/key/paddle inputs and ball/score outputs.
// Latency: wires only; no storage in the interface.
// Backpressure: none; every signal is a level or single-cycle pulse.
interface game_ctrl_if;
    logic       frame_tick;
    logic       start_key;
    logic [9:0] x;
    logic [9:0] x2;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic       move_en;
    logic       game_over;
    logic       winner;

    // Stimulus / consumer side (paddle logic, renderer, bench)
    modport master (
        output frame_tick, start_key, x, x2,
        input  ball_x, ball_y, p1_score, p2_score, move_en, game_over, winner
    );

    // The sequencer itself
    modport slave (
        input  frame_tick, start_key, x, x2,
        output ball_x, ball_y, p1_score, p2_score, move_en, game_over, winner
    );
endinterface

// File: rtl/game_ctrl.sv
// Match sequencer for the two-paddle game: ball motion, paddle hits, scoring, win.
// Latency: all outputs registered; state and ball update one clk after a sampled frame_tick/start_key.
// Backpressure: none; pulses are consumed in the cycle they arrive, ignored where a state has no use for them.
module game_ctrl #(
    parameter int VGA_XDIS     = 800,
    parameter int VGA_YDIS     = 600,
    parameter int SIDE         = 40,
    parameter int STICK        = 75,
    parameter int BALL         = 10,
    parameter int STEP         = 4,
    parameter int PY1          = 462,
    parameter int PY2          = 136,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    game_ctrl_if.slave    bus
);
    localparam int CW = $clog2(SERVE_FRAMES + 1);

    // 11-bit working constants so every sum and compare has headroom.
    localparam logic [10:0] SIDE_W  = 11'(SIDE);
    localparam logic [10:0] STEP_W  = 11'(STEP);
    localparam logic [10:0] BALL_W  = 11'(BALL);
    localparam logic [10:0] STICK_W = 11'(STICK);
    localparam logic [10:0] XMAX_W  = 11'(VGA_XDIS - SIDE - BALL);
    localparam logic [10:0] PY1_W   = 11'(PY1);
    localparam logic [10:0] PY1B_W  = 11'(PY1 - BALL);
    localparam logic [10:0] PY2_W   = 11'(PY2);
    localparam logic [9:0]  CX      = 10'((VGA_XDIS - BALL) / 2);
    localparam logic [9:0]  CY      = 10'((VGA_YDIS - BALL) / 2);
    localparam logic [3:0]  WIN_W   = 4'(WIN_SCORE);
    localparam logic [CW-1:0] SERVE_W = CW'(SERVE_FRAMES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVE,
        S_PLAY,
        S_SCORED,
        S_OVER
    } state_t;

    state_t        state_q, state_n;
    logic [9:0]    ball_x_q, ball_x_n;
    logic [9:0]    ball_y_q, ball_y_n;
    logic          dx_left_q, dx_left_n;   // 0 = moving right
    logic          dy_up_q, dy_up_n;       // 0 = moving down (toward player 1)
    logic [3:0]    p1_q, p1_n;
    logic [3:0]    p2_q, p2_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          scorer_q, scorer_n;     // 1 = player 2 took the point
    logic          move_en_q, move_en_n;
    logic          game_over_q, game_over_n;
    logic          winner_q, winner_n;

    logic [10:0]   bx, by, nx, ny;
    logic          nx_left;
    logic          p1_hit, p2_hit;
    logic [3:0]    cur_score, inc_score;
    logic [CW-1:0] cnt_inc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_n;
    end

    // Ball, score, counter and registered output flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ball_x_q    <= CX;
            ball_y_q    <= CY;
            dx_left_q   <= 1'b0;
            dy_up_q     <= 1'b0;
            p1_q        <= 4'd0;
            p2_q        <= 4'd0;
            cnt_q       <= '0;
            scorer_q    <= 1'b0;
            move_en_q   <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
        end else begin
            ball_x_q    <= ball_x_n;
            ball_y_q    <= ball_y_n;
            dx_left_q   <= dx_left_n;
            dy_up_q     <= dy_up_n;
            p1_q        <= p1_n;
            p2_q        <= p2_n;
            cnt_q       <= cnt_n;
            scorer_q    <= scorer_n;
            move_en_q   <= move_en_n;
            game_over_q <= game_over_n;
            winner_q    <= winner_n;
        end
    end

    // Next-state, ball motion, paddle hits and scoring
    always_comb begin
        state_n   = state_q;
        ball_x_n  = ball_x_q;
        ball_y_n  = ball_y_q;
        dx_left_n = dx_left_q;
        dy_up_n   = dy_up_q;
        p1_n      = p1_q;
        p2_n      = p2_q;
        cnt_n     = cnt_q;
        scorer_n  = scorer_q;
        winner_n  = winner_q;

        // Candidate position for this frame, x already clamped at the side walls.
        bx = {1'b0, ball_x_q};
        by = {1'b0, ball_y_q};
        if (dx_left_q) begin
            if (bx < SIDE_W + STEP_W) begin
                nx      = SIDE_W;
                nx_left = 1'b0;
            end else begin
                nx      = bx - STEP_W;
                nx_left = 1'b1;
            end
        end else begin
            if (bx + STEP_W > XMAX_W) begin
                nx      = XMAX_W;
                nx_left = 1'b1;
            end else begin
                nx      = bx + STEP_W;
                nx_left = 1'b0;
            end
        end
        ny = dy_up_q ? (by - STEP_W) : (by + STEP_W);

        p1_hit = (nx + BALL_W > {1'b0, bus.x})  && (nx < {1'b0, bus.x}  + STICK_W);
        p2_hit = (nx + BALL_W > {1'b0, bus.x2}) && (nx < {1'b0, bus.x2} + STICK_W);

        cur_score = scorer_q ? p2_q : p1_q;
        inc_score = (cur_score < WIN_W) ? cur_score + 4'd1 : cur_score;
        cnt_inc   = cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (bus.start_key) begin
                    state_n = S_SERVE;
                    cnt_n   = '0;
                end
            end
            S_SERVE: begin
                if (bus.frame_tick) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == SERVE_W) state_n = S_PLAY;
                end
            end
            S_PLAY: begin
                if (bus.frame_tick) begin
                    if (!dy_up_q && ny > PY1_W) begin
                        state_n  = S_SCORED;
                        scorer_n = 1'b1;
                    end else if (dy_up_q && ny + BALL_W < PY2_W) begin
                        state_n  = S_SCORED;
                        scorer_n = 1'b0;
                    end else begin
                        ball_x_n  = nx[9:0];
                        dx_left_n = nx_left;
                        ball_y_n  = ny[9:0];
                        if (!dy_up_q && by <= PY1B_W && ny > PY1B_W && p1_hit) begin
                            ball_y_n = PY1B_W[9:0];
                            dy_up_n  = 1'b1;
                        end else if (dy_up_q && by >= PY2_W && ny < PY2_W && p2_hit) begin
                            ball_y_n = PY2_W[9:0];
                            dy_up_n  = 1'b0;
                        end
                    end
                end
            end
            S_SCORED: begin
                if (scorer_q) p2_n = inc_score;
                else          p1_n = inc_score;
                ball_x_n = CX;
                ball_y_n = CY;
                if (inc_score == WIN_W) begin
                    state_n  = S_OVER;
                    winner_n = scorer_q;
                end else begin
                    // Serve toward whoever just lost the point.
                    state_n   = S_SERVE;
                    cnt_n     = '0;
                    dx_left_n = 1'b0;
                    dy_up_n   = !scorer_q;
                end
            end
            S_OVER: begin
                if (bus.start_key) begin
                    state_n = S_SERVE;
                    cnt_n   = '0;
                    p1_n    = 4'd0;
                    p2_n    = 4'd0;
                    dy_up_n = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase

        move_en_n   = (state_n == S_PLAY);
        game_over_n = (state_n == S_OVER);
    end

    assign bus.ball_x    = ball_x_q;
    assign bus.ball_y    = ball_y_q;
    assign bus.p1_score  = p1_q;
    assign bus.p2_score  = p2_q;
    assign bus.move_en   = move_en_q;
    assign bus.game_over = game_over_q;
    assign bus.winner    = winner_q;
endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed match scenarios against a frame-level behavioural model.
// Latency: model updates on the same clk edge as the DUT; outputs compared on every falling edge.
// Backpressure: none; stimulus is pulse-driven.
module tb_game_ctrl;
    localparam int XDIS  = 800;
    localparam int SIDE  = 40;
    localparam int STICK = 75;
    localparam int BALL  = 10;
    localparam int STEP  = 4;
    localparam int PY1   = 462;
    localparam int PY2   = 136;
    localparam int SERVE = 60;
    localparam int WIN   = 5;
    localparam int CX    = 395;
    localparam int CY    = 295;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    game_ctrl_if bus();

    game_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- behavioural model ----------------
    typedef enum {P_IDLE, P_SERVE, P_PLAY, P_SCORED, P_OVER} phase_e;
    phase_e m_ph  = P_IDLE;
    int m_bx = CX, m_by = CY, m_vx = STEP, m_vy = STEP;
    int m_s1 = 0, m_s2 = 0, m_cnt = 0, m_win = 0, m_scorer = 0;
    int t_nx, t_ny, t_vx, t_oy, t_ovy, t_new;

    function automatic bit overlap(input int ball_left, input int pad_left);
        return (ball_left < pad_left + STICK) && (pad_left < ball_left + BALL);
    endfunction

    // Frame-level game rules in plain integer arithmetic
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph = P_IDLE; m_bx = CX; m_by = CY; m_vx = STEP; m_vy = STEP;
            m_s1 = 0; m_s2 = 0; m_cnt = 0; m_win = 0;
        end else begin
            case (m_ph)
                P_IDLE: if (bus.start_key) begin m_ph = P_SERVE; m_cnt = 0; end
                P_SERVE: if (bus.frame_tick) begin
                    m_cnt++;
                    if (m_cnt == SERVE) m_ph = P_PLAY;
                end
                P_PLAY: if (bus.frame_tick) begin
                    t_nx = m_bx + m_vx; t_vx = m_vx;
                    if (t_nx < SIDE) begin t_nx = SIDE; t_vx = STEP; end
                    else if (t_nx > XDIS - SIDE - BALL) begin t_nx = XDIS - SIDE - BALL; t_vx = -STEP; end
                    t_ny = m_by + m_vy; t_oy = m_by; t_ovy = m_vy;
                    if (t_ovy > 0 && t_ny > PY1) begin m_ph = P_SCORED; m_scorer = 2; end
                    else if (t_ovy < 0 && t_ny + BALL < PY2) begin m_ph = P_SCORED; m_scorer = 1; end
                    else begin
                        m_bx = t_nx; m_vx = t_vx; m_by = t_ny;
                        if (t_ovy > 0 && t_oy <= PY1 - BALL && t_ny > PY1 - BALL && overlap(t_nx, int'(bus.x))) begin
                            m_by = PY1 - BALL; m_vy = -STEP;
                        end else if (t_ovy < 0 && t_oy >= PY2 && t_ny < PY2 && overlap(t_nx, int'(bus.x2))) begin
                            m_by = PY2; m_vy = STEP;
                        end
                    end
                end
                P_SCORED: begin
                    if (m_scorer == 2) begin if (m_s2 < WIN) m_s2++; t_new = m_s2; end
                    else begin if (m_s1 < WIN) m_s1++; t_new = m_s1; end
                    m_bx = CX; m_by = CY;
                    if (t_new == WIN) begin m_ph = P_OVER; m_win = m_scorer - 1; end
                    else begin
                        m_ph = P_SERVE; m_cnt = 0; m_vx = STEP;
                        m_vy = (m_scorer == 2) ? STEP : -STEP;
                    end
                end
                P_OVER: if (bus.start_key) begin
                    m_ph = P_SERVE; m_cnt = 0; m_s1 = 0; m_s2 = 0; m_vy = STEP;
                end
                default: m_ph = P_IDLE;
            endcase
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("cyc ball_x",    int'(bus.ball_x),    m_bx);
        chk("cyc ball_y",    int'(bus.ball_y),    m_by);
        chk("cyc p1_score",  int'(bus.p1_score),  m_s1);
        chk("cyc p2_score",  int'(bus.p2_score),  m_s2);
        chk("cyc move_en",   int'(bus.move_en),   (m_ph == P_PLAY) ? 1 : 0);
        chk("cyc game_over", int'(bus.game_over), (m_ph == P_OVER) ? 1 : 0);
        if (m_ph == P_OVER) chk("cyc winner", int'(bus.winner), m_win);
    endtask

    task automatic step(input logic ft, input logic sk);
        bus.frame_tick = ft;
        bus.start_key  = sk;
        @(posedge clk);
        #1;
        bus.frame_tick = 1'b0;
        bus.start_key  = 1'b0;
    endtask

    task automatic tick();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        bus.frame_tick = 1'b0;
        bus.start_key  = 1'b0;
        bus.x          = 10'd500;
        bus.x2         = 10'd600;
        repeat (2) @(posedge clk);
        #1;
        chk("rst ball_x", int'(bus.ball_x), 395);
        chk("rst ball_y", int'(bus.ball_y), 295);
        chk("rst p1", int'(bus.p1_score), 0);
        chk("rst p2", int'(bus.p2_score), 0);
        chk("rst move_en", int'(bus.move_en), 0);
        chk("rst game_over", int'(bus.game_over), 0);
        chk("rst winner", int'(bus.winner), 0);
        rst_n = 1'b1;

        fork
            forever begin
                @(negedge clk);
                compare_all();
            end
        join_none

        // Idle ignores frame ticks
        repeat (100) tick();
        chk("idle ball_x", int'(bus.ball_x), 395);
        chk("idle ball_y", int'(bus.ball_y), 295);
        chk("idle move_en", int'(bus.move_en), 0);

        // Serve countdown, then first moves with paddle at 500
        step(1'b0, 1'b1);
        repeat (59) tick();
        chk("serve59 move_en", int'(bus.move_en), 0);
        tick();
        chk("serve60 move_en", int'(bus.move_en), 1);
        chk("serve60 ball_x", int'(bus.ball_x), 395);
        chk("serve60 ball_y", int'(bus.ball_y), 295);
        tick();
        chk("play1 ball_x", int'(bus.ball_x), 399);
        chk("play1 ball_y", int'(bus.ball_y), 299);
        repeat (38) tick();
        step(1'b0, 1'b1);
        chk("play start ignored", int'(bus.move_en), 1);
        tick();
        chk("hit40 ball_x", int'(bus.ball_x), 555);
        chk("hit40 ball_y", int'(bus.ball_y), 452);
        repeat (49) tick();
        chk("wall89 ball_x", int'(bus.ball_x), 750);
        tick();
        chk("wall90 ball_x", int'(bus.ball_x), 746);
        repeat (30) tick();
        chk("top120 ball_x", int'(bus.ball_x), 626);
        chk("top120 ball_y", int'(bus.ball_y), 136);
        tick();
        chk("top121 ball_y", int'(bus.ball_y), 140);

        // Asynchronous reset mid-play, checked before any further clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("arst ball_x", int'(bus.ball_x), 395);
        chk("arst ball_y", int'(bus.ball_y), 295);
        chk("arst move_en", int'(bus.move_en), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Player 1 paddle parked at the left: every serve is a miss
        bus.x = 10'd40;
        step(1'b0, 1'b1);
        repeat (60) tick();
        repeat (39) tick();
        tick();
        chk("miss40 ball_y", int'(bus.ball_y), 455);
        tick();
        chk("miss41 ball_y", int'(bus.ball_y), 459);
        tick();
        chk("miss42 p2", int'(bus.p2_score), 1);
        chk("miss42 move_en", int'(bus.move_en), 0);
        chk("miss42 ball_x", int'(bus.ball_x), 395);
        chk("miss42 ball_y", int'(bus.ball_y), 295);

        for (int i = 2; i <= 5; i++) begin
            repeat (61) tick();
            chk("reserve ball_y", int'(bus.ball_y), 299);
            repeat (41) tick();
            chk("point p2", int'(bus.p2_score), i);
        end
        chk("over game_over", int'(bus.game_over), 1);
        chk("over winner", int'(bus.winner), 1);
        chk("over p1", int'(bus.p1_score), 0);
        repeat (5) tick();
        chk("over ball_x", int'(bus.ball_x), 395);

        // Restart from game over
        step(1'b0, 1'b1);
        chk("restart p2", int'(bus.p2_score), 0);
        chk("restart game_over", int'(bus.game_over), 0);
        repeat (60) tick();
        chk("restart move_en", int'(bus.move_en), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
